// File: rtl/plab4_net_router_output_terminal_ctrl_pkg.sv
// Shared definitions for the router output-port controller.
//   - Route / crossbar-select codes (prev, term, next).
//   - Bit positions of the three input-controller requests.
//   - Reset value of the round-robin priority pointer.
//   - Helpers to encode a one-hot winner and to rotate a pointer.
package plab4_net_router_output_terminal_ctrl_pkg;

  // Route codes, reused directly as the crossbar select encoding.
  localparam logic [1:0] RoutePrev = 2'd0;
  localparam logic [1:0] RouteTerm = 2'd1;
  localparam logic [1:0] RouteNext = 2'd2;

  // Request / grant bit order.
  localparam int unsigned ReqPrevBit = 0;
  localparam int unsigned ReqTermBit = 1;
  localparam int unsigned ReqNextBit = 2;

  // Pointer value after reset: the prev input has highest priority.
  localparam logic [2:0] PrioReset = 3'b001;

  // One-hot winner to crossbar select; zero vector maps to RoutePrev.
  function automatic logic [1:0] enc_route(input logic [2:0] onehot);
    logic [1:0] route;
    route = RoutePrev;
    if (onehot[ReqTermBit]) route = RouteTerm;
    if (onehot[ReqNextBit]) route = RouteNext;
    return route;
  endfunction

  // Rotate left by one (bit0->1->2->0): the winner drops to lowest priority.
  function automatic logic [2:0] rotl3(input logic [2:0] onehot);
    return {onehot[1:0], onehot[2]};
  endfunction

endpackage

// File: rtl/plab4_net_RoundRobinArbiter3.sv
// Three-way round-robin arbiter (purely combinational).
// Ports:
//   prio   in  3  one-hot pointer marking the highest-priority request bit
//   reqs   in  3  request vector
//   winner out 3  one-hot winner, or zero when no request is set
// The search starts at the pointer bit and proceeds upward, wrapping 2->0.
module plab4_net_RoundRobinArbiter3
  import plab4_net_router_output_terminal_ctrl_pkg::*;
(
  input  logic [2:0] prio,
  input  logic [2:0] reqs,
  output logic [2:0] winner
);

  always_comb begin
    winner = 3'b000;
    unique case (prio)
      3'b010: begin
        if      (reqs[ReqTermBit]) winner = 3'b010;
        else if (reqs[ReqNextBit]) winner = 3'b100;
        else if (reqs[ReqPrevBit]) winner = 3'b001;
      end
      3'b100: begin
        if      (reqs[ReqNextBit]) winner = 3'b100;
        else if (reqs[ReqPrevBit]) winner = 3'b001;
        else if (reqs[ReqTermBit]) winner = 3'b010;
      end
      // 3'b001 and any malformed pointer fall back to prev-first order so the
      // output stays defined.
      default: begin
        if      (reqs[ReqPrevBit]) winner = 3'b001;
        else if (reqs[ReqTermBit]) winner = 3'b010;
        else if (reqs[ReqNextBit]) winner = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/plab4_net_router_output_terminal_ctrl.sv
// Router output-port controller: round-robin arbitration among the prev,
// terminal and next input controllers, with per-security-domain pointer and
// saturating transfer counter.
// Ports:
//   clk        in   1            clock
//   reset      in   1            asynchronous active-low reset
//   cur_sd     in   1            security domain selecting pointer and counter
//   reqs       in   3            requests (bit0 prev, bit1 term, bit2 next)
//   grants     out  3            one-hot grant, only when out_rdy is high
//   out_val    out  1            output valid (any request)
//   out_rdy    in   1            output ready
//   sel        out  2            crossbar select (0 prev, 1 term, 2 next)
//   xfer_count out  p_cnt_nbits  transfer count of cur_sd
module plab4_net_router_output_terminal_ctrl
  import plab4_net_router_output_terminal_ctrl_pkg::*;
#(
  parameter int          p_router_id = 0,
  parameter int unsigned p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cur_sd,
  input  logic [2:0]             reqs,
  output logic [2:0]             grants,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [1:0]             sel,
  output logic [p_cnt_nbits-1:0] xfer_count
);

  // Elaboration-time sanity check on the parameters.
  if (p_router_id < 0 || p_cnt_nbits < 1) begin : g_bad_params
    $error("plab4_net_router_output_terminal_ctrl: bad parameters");
  end

  localparam logic [p_cnt_nbits-1:0] CntMax = {p_cnt_nbits{1'b1}};

  // Per-domain state; index 0/1 is the security domain.
  logic [2:0]             prio_q [2];
  logic [p_cnt_nbits-1:0] cnt_q  [2];

  logic [2:0]             prio_act;
  logic [p_cnt_nbits-1:0] cnt_act;
  logic [2:0]             winner;
  logic                   xfer;
  logic [2:0]             prio_d;
  logic [p_cnt_nbits-1:0] cnt_d;

  // Only the active domain's entries are ever selected or updated.
  assign prio_act = prio_q[cur_sd];
  assign cnt_act  = cnt_q[cur_sd];

  plab4_net_RoundRobinArbiter3 u_arb (
    .prio   (prio_act),
    .reqs   (reqs),
    .winner (winner)
  );

  always_comb begin
    out_val    = |reqs;
    sel        = enc_route(winner);
    grants     = out_rdy ? winner : 3'b000;
    xfer_count = cnt_act;
    xfer       = out_val & out_rdy;
    prio_d     = rotl3(winner);
    cnt_d      = (cnt_act == CntMax) ? cnt_act : cnt_act + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q[0] <= PrioReset;
      prio_q[1] <= PrioReset;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else if (xfer) begin
      prio_q[cur_sd] <= prio_d;
      cnt_q[cur_sd]  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_terminal_ctrl.sv
// Directed bench with a scoreboard: each step pushes its expected outputs,
// then pops and compares them against the DUT shortly after driving inputs.
// A second instance with 2-bit counters shares all inputs to observe
// saturation; its expected count is the true count clipped at 3.
module tb_plab4_net_router_output_terminal_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cur_sd = 1'b0;
  logic [2:0]  reqs = 3'b000;
  logic        out_rdy = 1'b0;

  logic [2:0]  grants, grants_s;
  logic        out_val, out_val_s;
  logic [1:0]  sel, sel_s;
  logic [15:0] xfer_count;
  logic [1:0]  xfer_count_s;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [2:0]  grants;
    logic        val;
    logic [1:0]  sel;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  plab4_net_router_output_terminal_ctrl #(
    .p_router_id (0),
    .p_cnt_nbits (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cur_sd     (cur_sd),
    .reqs       (reqs),
    .grants     (grants),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .sel        (sel),
    .xfer_count (xfer_count)
  );

  plab4_net_router_output_terminal_ctrl #(
    .p_router_id (1),
    .p_cnt_nbits (2)
  ) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .cur_sd     (cur_sd),
    .reqs       (reqs),
    .grants     (grants_s),
    .out_val    (out_val_s),
    .out_rdy    (out_rdy),
    .sel        (sel_s),
    .xfer_count (xfer_count_s)
  );

  task automatic push(input string tag, input logic [2:0] eg, input logic [1:0] es,
                      input logic [15:0] ec);
    exp_t e;
    e.tag     = tag;
    e.grants  = eg;
    e.val     = |reqs;
    e.sel     = es;
    e.cnt     = ec;
    e.cnt_sat = (ec > 16'd3) ? 2'd3 : ec[1:0];
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    e = sb.pop_front();
    compared++;
    assert (grants === e.grants) else begin
      mismatched++;
      $error("FAIL %s grants: got %b want %b", e.tag, grants, e.grants);
    end
    compared++;
    assert (out_val === e.val) else begin
      mismatched++;
      $error("FAIL %s out_val: got %b want %b", e.tag, out_val, e.val);
    end
    compared++;
    assert (sel === e.sel) else begin
      mismatched++;
      $error("FAIL %s sel: got %0d want %0d", e.tag, sel, e.sel);
    end
    compared++;
    assert (xfer_count === e.cnt) else begin
      mismatched++;
      $error("FAIL %s xfer_count: got %0d want %0d", e.tag, xfer_count, e.cnt);
    end
    compared++;
    assert (xfer_count_s === e.cnt_sat) else begin
      mismatched++;
      $error("FAIL %s sat_count: got %0d want %0d", e.tag, xfer_count_s, e.cnt_sat);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and check 1 time unit later.
  task automatic step(input string tag, input logic sd, input logic [2:0] rq,
                      input logic rdy, input logic [2:0] eg, input logic [1:0] es,
                      input logic [15:0] ec);
    @(negedge clk);
    cur_sd  = sd;
    reqs    = rq;
    out_rdy = rdy;
    push(tag, eg, es, ec);
    #1;
    pop_compare();
  endtask

  initial begin
    // Reset held: reset-state outputs.
    #2;
    push("reset_hold", 3'b000, 2'd0, 16'd0);
    #1;
    pop_compare();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Full contention in domain 0 rotates 001 -> 010 -> 100.
    step("rr0", 1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 16'd0);
    step("rr1", 1'b0, 3'b111, 1'b1, 3'b010, 2'd1, 16'd1);
    step("rr2", 1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 16'd2);

    // Stall: valid and select present, no grant, no state change.
    for (int i = 0; i < 4; i++) begin
      step("stall", 1'b0, 3'b110, 1'b0, 3'b000, 2'd1, 16'd3);
    end
    step("unstall", 1'b0, 3'b110, 1'b1, 3'b010, 2'd1, 16'd3);
    // Pointer now 100: with all requests the next input wins.
    step("prio_100", 1'b0, 3'b111, 1'b0, 3'b000, 2'd2, 16'd4);

    // Domain isolation.
    step("d0_next", 1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 16'd4);
    step("d0_prev", 1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 16'd5);
    step("d1_first", 1'b1, 3'b111, 1'b1, 3'b001, 2'd0, 16'd0);
    step("d1_after", 1'b1, 3'b000, 1'b1, 3'b000, 2'd0, 16'd1);
    step("d0_back", 1'b0, 3'b111, 1'b0, 3'b000, 2'd1, 16'd6);

    // Single requester keeps winning; pointer ends at 001.
    for (int i = 0; i < 5; i++) begin
      step("single", 1'b0, 3'b100, 1'b1, 3'b100, 2'd2, 16'(6 + i));
    end
    step("single_end", 1'b0, 3'b111, 1'b0, 3'b000, 2'd0, 16'd11);

    // Move pointer to 010, stall, then assert reset between edges.
    step("pre_rst", 1'b0, 3'b001, 1'b1, 3'b001, 2'd0, 16'd11);
    step("rst_stall", 1'b0, 3'b101, 1'b0, 3'b000, 2'd2, 16'd12);
    #2;
    reset = 1'b0;
    push("rst_async", 3'b000, 2'd0, 16'd0);
    #1;
    pop_compare();
    cur_sd = 1'b1;
    push("rst_async_d1", 3'b000, 2'd0, 16'd0);
    #1;
    pop_compare();
    @(negedge clk);
    reset = 1'b1;

    // First grant after release is 001; then count through saturation.
    step("post_rst", 1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 16'd0);
    step("sat1", 1'b0, 3'b111, 1'b1, 3'b010, 2'd1, 16'd1);
    step("sat2", 1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 16'd2);
    step("sat3", 1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 16'd3);
    step("sat4", 1'b0, 3'b111, 1'b1, 3'b010, 2'd1, 16'd4);
    step("sat5", 1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 16'd5);
    step("sat_end", 1'b0, 3'b000, 1'b1, 3'b000, 2'd0, 16'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_output_terminal_ctrl.md
Name: plab4_net_router_output_terminal_ctrl

Overview:
- Output-port controller for one router output (prev, term or next); the counterpart of the router input controllers that raise requests.
- Receives one request bit from each of the three input controllers and arbitrates among them round-robin.
- Drives grants back to the inputs, drives the output valid and the crossbar select, and completes the val/rdy handshake with the downstream channel.
- Keeps a separate priority pointer and transfer counter per security domain, so arbitration history in one domain never influences the other.

Parameters:
- p_router_id, 0, router index (informational; passed through for tracing)
- p_cnt_nbits, 16, width of the per-domain saturating transfer counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- cur_sd  in  1  current security domain (public label); selects the pointer and counter in use
- reqs  in  3  requests; bit0 = prev-input ctrl, bit1 = terminal-input ctrl, bit2 = next-input ctrl
- grants  out  3  one-hot or zero grant, same bit order as reqs
- out_val  out  1  output channel valid
- out_rdy  in  1  output channel ready
- sel  out  2  crossbar select: 0 = prev, 1 = term, 2 = next
- xfer_count  out  p_cnt_nbits  transfer count for cur_sd

Behaviour:
- State:
  - prio[0], prio[1]: 3-bit one-hot priority pointers.
  - cnt[0], cnt[1]: p_cnt_nbits each.
- Reset (reset==0, async): prio[*]=3'b001, cnt[*]=0. While reset is held, outputs follow the combinational rules below with the reset state, so with reqs=0: grants=0, out_val=0, sel=0, xfer_count=0.
- Arbitration (combinational, same cycle as reqs):
  - Active pointer p = prio[cur_sd].
  - Winner = first set bit of reqs, searching circularly from the bit marked by p upward (bit0->1->2->0).
- out_val = |reqs. Zero cycles of latency from reqs.
- sel = encoded winner when out_val=1; sel = 0 when reqs=0.
- grants = out_rdy ? onehot(winner) : 3'b000. Never more than one bit set. Never set without the matching reqs bit.
- Transfer occurs when out_val && out_rdy. On the next rising clk edge:
  - prio[cur_sd] <= rotate-left-by-one of onehot(winner), so the winner gets lowest priority next time.
  - cnt[cur_sd] <= cnt[cur_sd]+1, saturating at all-ones (no wrap).
- No transfer: prio and cnt are unchanged. A request held with out_rdy=0 keeps its position; no grant is issued.
- The pointer and counter of the inactive domain are never read or written.
- A cur_sd change takes effect in the same cycle: arbitration uses the other pointer immediately. No state carries across domains.
- xfer_count = cnt[cur_sd] (combinational mux).
- Reset asserted mid-operation: state clears immediately regardless of clk. The first edge after reset deasserts behaves exactly like the first edge after power-up.
- No X propagation: all outputs are defined for every input combination, including reqs=0.

Decomposition:
- Shared package/header gets:
  - the `ROUTE_PREV/`ROUTE_TERM/`ROUTE_NEXT codes, reused as sel encodings 0/1/2;
  - the 3-bit request bit-order constants;
  - the reset pointer value 3'b001.
- Natural sub-module: plab4_net_RoundRobinArbiter3. It takes pointer and reqs and returns the one-hot winner; it is purely combinational.
- Pointer storage, per-domain selection and counters stay in the top module.

Test Plan:
- Reset then reqs=3'b111, out_rdy=1, cur_sd=0 for 3 cycles:
  - grants 001, 010, 100 in that order;
  - sel 0, 1, 2;
  - xfer_count 1, 2, 3 on the following cycles.
- reqs=3'b110, out_rdy=0 for 4 cycles, then out_rdy=1:
  - out_val=1 and grants=000 while stalled;
  - then grants=010, sel=1;
  - prio[0] becomes 100.
- Domain isolation:
  - sequence: cur_sd=0, reqs=3'b111, one transfer (grant 001); switch to cur_sd=1 with reqs=3'b111;
  - required: grant 001 (domain-1 pointer untouched), xfer_count=0 before the edge, 1 after.
- Single requester reqs=3'b100, out_rdy=1 for 5 cycles:
  - grants=100 every cycle;
  - prio[0] ends at 001;
  - xfer_count=5.
- p_cnt_nbits=2 with 6 continuous transfers: xfer_count goes 1, 2, 3, 3, 3, 3 (saturates, no wrap).
- Reset asserted between edges during a stalled request:
  - outputs show the reset state immediately;
  - after release with reqs=3'b111, the first grant is 001.
